// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and defaults for the game round logic
package game_pkg;

    typedef logic [5:0] state_t;

    localparam state_t ST_STARTGAME  = 6'b000001;
    localparam state_t ST_IDLE       = 6'b000010;
    localparam state_t ST_PLAY       = 6'b000100;
    localparam state_t ST_FLASH      = 6'b001000;
    localparam state_t ST_PADDLEFALL = 6'b010000;
    localparam state_t ST_NOPADDLES  = 6'b100000;

    localparam int STARTGAME_BIT  = 0;
    localparam int IDLE_BIT       = 1;
    localparam int PLAY_BIT       = 2;
    localparam int FLASH_BIT      = 3;
    localparam int PADDLEFALL_BIT = 4;
    localparam int NOPADDLES_BIT  = 5;

    localparam int DEFAULT_START_LIVES = 3;

    function automatic logic is_one_hot(input state_t v);
        return (v != '0) && ((v & (v - state_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/game_round_sequencer_if.sv
// rtl/game_round_sequencer_if.sv - state/strobe/status bundle between the FSM logic and its sequencer
interface game_round_sequencer_if;
    import game_pkg::*;

    state_t NS;
    state_t PS;
    logic   resettimer;
    logic   timecount;
    logic   decrementlives;
    logic   loadlives;
    logic   foursec;
    logic   nolives;
    logic   pb1;
    logic   pb2;

    modport master (
        output NS, resettimer, timecount, decrementlives, loadlives,
        input  PS, foursec, nolives, pb1, pb2
    );

    modport slave (
        input  NS, resettimer, timecount, decrementlives, loadlives,
        output PS, foursec, nolives, pb1, pb2
    );
endinterface

// File: rtl/game_round_sequencer_button.sv
// rtl/game_round_sequencer_button.sv - button_conditioner: two-flop synchronizer plus debounce
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any sample agreeing with the output restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/game_round_sequencer.sv
// rtl/game_round_sequencer.sv - state register, button conditioning, hold timer and lives counter around the game FSM
module game_round_sequencer
    import game_pkg::*;
#(
    parameter int CYCLES_PER_SEC  = 50_000_000,
    parameter int HOLD_SECONDS    = 4,
    parameter int START_LIVES     = DEFAULT_START_LIVES,
    parameter int LIVES_W         = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pb1_raw,
    input  logic                   pb2_raw,
    game_round_sequencer_if.slave  bus,
    output logic [LIVES_W-1:0]     lives,
    output logic                   state_err
);
    localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam int SW = $clog2(HOLD_SECONDS + 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [SW-1:0] sec_q;
    logic [SW-1:0] sec_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pb1 (
        .clk   (clk),
        .reset (reset),
        .raw   (pb1_raw),
        .level (bus.pb1)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pb2 (
        .clk   (clk),
        .reset (reset),
        .raw   (pb2_raw),
        .level (bus.pb2)
    );

    // An illegal next state falls back to startgame rather than wedging the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.PS    <= ST_STARTGAME;
            state_err <= 1'b0;
        end else if (is_one_hot(bus.NS)) begin
            bus.PS <= bus.NS;
        end else begin
            bus.PS    <= ST_STARTGAME;
            state_err <= 1'b1;
        end
    end

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        if (bus.resettimer) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (bus.timecount) begin
            if (presc_q == PW'(CYCLES_PER_SEC - 1)) begin
                presc_d = '0;
                if (sec_q != SW'(HOLD_SECONDS))
                    sec_d = sec_q + SW'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // foursec follows the next-state second count so it rises on the final counting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            sec_q       <= '0;
            bus.foursec <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            bus.foursec <= (sec_d == SW'(HOLD_SECONDS));
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.loadlives)
            lives <= LIVES_W'(START_LIVES);
        else if (bus.decrementlives && (lives != '0))
            lives <= lives - LIVES_W'(1);
    end

    assign bus.nolives = (lives == '0);

endmodule

// File: tb/tb_game_round_sequencer.sv
// tb/tb_game_round_sequencer.sv - self-checking bench for game_round_sequencer
module tb_game_round_sequencer;
    import game_pkg::*;

    localparam int CPS   = 10;
    localparam int HOLD  = 4;
    localparam int DEB   = 5;
    localparam int START = 3;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pb1_raw = 1'b0;
    logic          pb2_raw = 1'b0;
    logic [LW-1:0] lives;
    logic          state_err;

    game_round_sequencer_if bus();

    game_round_sequencer #(
        .CYCLES_PER_SEC(CPS), .HOLD_SECONDS(HOLD), .START_LIVES(START),
        .LIVES_W(LW), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pb1_raw   (pb1_raw),
        .pb2_raw   (pb2_raw),
        .bus       (bus),
        .lives     (lives),
        .state_err (state_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Directly driven stimulus, or the small game FSM in closed loop.
    bit     loop_en = 1'b0;
    state_t ns_drv = ST_STARTGAME;
    bit     rt_drv = 0, tc_drv = 0, dec_drv = 0, load_drv = 0;
    bit     collision = 0;
    state_t fsm_ns;
    logic   fsm_rt, fsm_tc, fsm_dec, fsm_load;

    always_comb begin
        fsm_ns = bus.PS; fsm_rt = 0; fsm_tc = 0; fsm_dec = 0; fsm_load = 0;
        case (bus.PS)
            ST_STARTGAME: begin
                fsm_load = 1; fsm_rt = 1;
                fsm_ns = bus.pb2 ? ST_PLAY : ST_STARTGAME;
            end
            ST_PLAY: if (collision) begin
                fsm_dec = 1; fsm_rt = 1; fsm_ns = ST_FLASH;
            end
            ST_FLASH: begin
                fsm_tc = 1;
                if (bus.foursec) fsm_ns = bus.nolives ? ST_NOPADDLES : ST_PLAY;
            end
            ST_NOPADDLES: if (bus.pb1) fsm_ns = ST_STARTGAME;
            default: fsm_ns = ST_STARTGAME;
        endcase
    end

    assign bus.NS             = loop_en ? fsm_ns   : ns_drv;
    assign bus.resettimer     = loop_en ? fsm_rt   : rt_drv;
    assign bus.timecount      = loop_en ? fsm_tc   : tc_drv;
    assign bus.decrementlives = loop_en ? fsm_dec  : dec_drv;
    assign bus.loadlives      = loop_en ? fsm_load : load_drv;

    // Reference model: state legality, elapsed counting cycles, lives arithmetic,
    // and a button rule phrased over the raw-sample history.
    int     m_ps, m_err, m_lives, m_count, m_four;
    int     m_pb[2];
    int     m_hist[2][7];
    logic   raw_now[2];

    always @(posedge clk) begin
        raw_now[0] = pb1_raw;
        raw_now[1] = pb2_raw;
        if (reset) begin
            m_ps = 1; m_err = 0; m_lives = START; m_count = 0; m_four = 0;
            for (int b = 0; b < 2; b++) begin
                m_pb[b] = 0;
                for (int i = 0; i < 7; i++) m_hist[b][i] = 0;
            end
        end else begin
            if ($countones(bus.NS) == 1) m_ps = int'(bus.NS);
            else begin m_ps = 1; m_err = 1; end
            if (bus.resettimer) m_count = 0;
            else if (bus.timecount && m_count < 1000) m_count++;
            m_four = (m_count >= CPS * HOLD) ? 1 : 0;
            if (bus.loadlives) m_lives = START;
            else if (bus.decrementlives && m_lives > 0) m_lives--;
            for (int b = 0; b < 2; b++) begin
                bit all_other;
                for (int i = 6; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
                m_hist[b][0] = int'(raw_now[b]);
                all_other = 1;
                for (int i = 2; i <= 6; i++)
                    if (m_hist[b][i] == m_pb[b]) all_other = 0;
                if (all_other) m_pb[b] = 1 - m_pb[b];
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_PS", int'(bus.PS), m_ps);
            chk("model_state_err", int'(state_err), m_err);
            chk("model_lives", int'(lives), m_lives);
            chk("model_nolives", int'(bus.nolives), (m_lives == 0) ? 1 : 0);
            chk("model_foursec", int'(bus.foursec), m_four);
            chk("model_pb1", int'(bus.pb1), m_pb[0]);
            chk("model_pb2", int'(bus.pb2), m_pb[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset holds PS at startgame even with a legal NS driven.
        reset = 1; ns_drv = ST_PLAY;
        tick();
        check_en = 1;
        tick();
        chk("reset_PS", int'(bus.PS), 1);
        chk("reset_lives", int'(lives), 3);
        chk("reset_nolives", int'(bus.nolives), 0);
        chk("reset_foursec", int'(bus.foursec), 0);
        reset = 0;
        tick();
        chk("release_PS", int'(bus.PS), 4);

        ns_drv = 6'b000110; tick();
        chk("illegal_multi_PS", int'(bus.PS), 1);
        chk("illegal_multi_err", int'(state_err), 1);
        ns_drv = 6'b000000; tick();
        chk("illegal_zero_PS", int'(bus.PS), 1);
        ns_drv = ST_IDLE; tick(); tick();
        chk("legal_after_err_PS", int'(bus.PS), 2);
        chk("err_sticky", int'(state_err), 1);

        rt_drv = 1; tick(); rt_drv = 0;
        tc_drv = 1; repeat (25) tick();
        chk("timer_25", int'(bus.foursec), 0);
        tc_drv = 0; repeat (10) tick();
        chk("timer_paused", int'(bus.foursec), 0);
        tc_drv = 1; repeat (14) tick();
        chk("timer_39", int'(bus.foursec), 0);
        tick();
        chk("timer_40", int'(bus.foursec), 1);
        tc_drv = 0; repeat (3) tick();
        chk("timer_hold_high", int'(bus.foursec), 1);
        rt_drv = 1; tick(); rt_drv = 0;
        chk("timer_cleared", int'(bus.foursec), 0);

        dec_drv = 1;
        tick(); chk("lives_2", int'(lives), 2);
        tick(); chk("lives_1", int'(lives), 1);
        tick(); chk("lives_0", int'(lives), 0);
        chk("nolives_set", int'(bus.nolives), 1);
        tick(); chk("lives_sat", int'(lives), 0);
        load_drv = 1; tick();
        chk("lives_load_priority", int'(lives), 3);
        chk("nolives_clear", int'(bus.nolives), 0);
        dec_drv = 0; load_drv = 0;

        for (int i = 0; i < 20; i++) begin
            pb2_raw = ((i / 2) % 2 == 0);
            tick();
            chk("bounce_pb2_low", int'(bus.pb2), 0);
        end
        pb2_raw = 1; repeat (6) tick();
        chk("deb_rise_6", int'(bus.pb2), 0);
        tick();
        chk("deb_rise_7", int'(bus.pb2), 1);
        pb2_raw = 0; repeat (6) tick();
        chk("deb_fall_6", int'(bus.pb2), 1);
        tick();
        chk("deb_fall_7", int'(bus.pb2), 0);

        // Closed loop with the bench FSM.
        reset = 1; tick(); reset = 0; loop_en = 1;
        pb2_raw = 1;
        for (int i = 0; i < 30 && bus.PS != ST_PLAY; i++) tick();
        chk("loop_play", int'(bus.PS), int'(ST_PLAY));
        chk("loop_lives_loaded", int'(lives), 3);
        pb2_raw = 0;
        for (int k = 0; k < 3; k++) begin
            collision = 1; tick(); collision = 0;
            chk("loop_flash", int'(bus.PS), int'(ST_FLASH));
            for (int i = 0; i < 80 && bus.PS == ST_FLASH; i++) tick();
        end
        chk("loop_nopaddles", int'(bus.PS), int'(ST_NOPADDLES));
        chk("loop_nolives", int'(bus.nolives), 1);
        pb1_raw = 1;
        for (int i = 0; i < 30 && bus.PS != ST_STARTGAME; i++) tick();
        chk("loop_restart", int'(bus.PS), int'(ST_STARTGAME));
        pb1_raw = 0; loop_en = 0;
        repeat (10) tick();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 4) != 0) ns_drv = state_t'(1 << $urandom_range(0, 5));
            else ns_drv = state_t'($urandom);
            rt_drv   = ($urandom_range(0, 29) == 0);
            tc_drv   = ($urandom_range(0, 9) < 7);
            dec_drv  = ($urandom_range(0, 9) == 0);
            load_drv = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) pb1_raw = ~pb1_raw;
            if ($urandom_range(0, 5) == 0) pb2_raw = ~pb2_raw;
            tick();
        end

        reset = 1; tick();
        chk("final_reset_PS", int'(bus.PS), 1);
        chk("final_reset_err", int'(state_err), 0);
        chk("final_reset_lives", int'(lives), 3);
        chk("final_reset_pb", int'({bus.pb1, bus.pb2}), 0);
        chk("final_reset_foursec", int'(bus.foursec), 0);
        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_round_sequencer.md
Name: game_round_sequencer

Overview:
- Sequential shell around the combinational game FSM next-state/output block.
- Holds the one-hot state register and feeds PS to that block; takes NS back.
- Conditions the two pushbuttons, runs the four-second hold timer (foursec), and keeps the lives counter (nolives).
- Consumes the FSM's resettimer, timecount, decrementlives and loadlives strobes. Sits between board I/O and the FSM in the game top level.

Parameters:
- CYCLES_PER_SEC, 50_000_000: clock cycles per timer second.
- HOLD_SECONDS, 4: seconds counted before foursec asserts.
- START_LIVES, 3: value loaded on loadlives and at reset; must satisfy 1..2^LIVES_W-1.
- LIVES_W, 3: width of the lives counter.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a button output changes.

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high reset.
- pb1_raw in 1: raw pushbutton 1, asynchronous, bouncing.
- pb2_raw in 1: raw pushbutton 2, asynchronous, bouncing.
- NS in 6: next state from FSM logic (bit0 startgame, 1 idle, 2 play, 3 flash, 4 paddlefall, 5 nopaddles).
- resettimer in 1: clear hold timer.
- timecount in 1: advance hold timer.
- decrementlives in 1: lose one life.
- loadlives in 1: reload START_LIVES.
- PS out 6: registered one-hot present state.
- pb1 out 1: conditioned level of button 1.
- pb2 out 1: conditioned level of button 2.
- foursec out 1: hold time elapsed.
- nolives out 1: lives counter is zero.
- lives out LIVES_W: current lives, for display.
- state_err out 1: sticky flag, non-one-hot NS was seen.

Behaviour:
- Reset (synchronous, all registers):
  - PS=6'b000001, lives=START_LIVES.
  - pb1=pb2=0, foursec=0, nolives=0, state_err=0.
  - Prescaler, second counter and debounce counters all 0.
- State register:
  - Each cycle PS<=NS if NS has exactly one bit set.
  - Otherwise (zero or multiple bits set) PS<=6'b000001 and state_err<=1.
  - state_err clears only on reset.
- Button conditioning, per button:
  - Two-flop synchronizer, then debounce.
  - Debounce counter resets whenever the synchronized input equals the current output.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES-1 the output takes the input value and the counter clears.
  - Any bounce back to the output value restarts the count.
  - Latency from a clean edge on *_raw: 2 synchronizer cycles + DEBOUNCE_CYCLES.
  - Outputs are levels; no edge detection.
- Hold timer:
  - Prescaler counts 0..CYCLES_PER_SEC-1; second counter counts 0..HOLD_SECONDS.
  - resettimer has priority: both counters to 0, foursec<=0 next cycle.
  - Else if timecount=1: prescaler increments. On wrap from CYCLES_PER_SEC-1 to 0, the second counter increments and saturates at HOLD_SECONDS.
  - Else (timecount=0): both counters hold, so time is paused, not cleared.
  - foursec is registered and equals (second counter == HOLD_SECONDS). It stays high until resettimer.
  - From the clear, foursec rises at the clock edge ending the (HOLD_SECONDS×CYCLES_PER_SEC)th counting cycle.
- Lives:
  - loadlives has priority: lives<=START_LIVES.
  - Else if decrementlives: lives<=lives-1, saturating at 0 (no wrap).
  - nolives = (lives==0), decoded combinationally from the register.
  - Decrement and reset-timer strobes arrive in the same cycle (collision or paddlegone); both take effect independently in that cycle.
- Reset mid-round: everything returns to the reset values above next edge; no partial state survives.

Decomposition:
- Shared package game_pkg:
  - One-hot state constants ST_STARTGAME=6'b000001, ST_IDLE=6'b000010, ST_PLAY=6'b000100, ST_FLASH=6'b001000, ST_PADDLEFALL=6'b010000, ST_NOPADDLES=6'b100000.
  - State bit-index constants.
  - Default START_LIVES.
- One sub-module, button_conditioner (synchronizer + debounce, parameter DEBOUNCE_CYCLES), instantiated for pb1 and pb2.

Test Plan:
All tests use CYCLES_PER_SEC=10, HOLD_SECONDS=4, DEBOUNCE_CYCLES=5, START_LIVES=3, LIVES_W=3.
- Reset check: assert reset 2 cycles, drive NS=6'b000100 → PS=000001, lives=3, nolives=0, foursec=0; first edge after reset releases gives PS=000100.
- Illegal NS: drive NS=6'b000110, then NS=6'b000000 → PS=000001 after each; state_err=1 and held through later legal NS until reset.
- Timer run and pause:
  - Pulse resettimer, then timecount=1 for 25 cycles → foursec=0.
  - Drop timecount for 10 cycles → counters frozen.
  - Raise timecount for 15 more cycles → foursec=1 on the 40th counting edge; stays 1 with timecount=0.
  - resettimer pulse → foursec=0 next cycle.
- Lives:
  - Three decrementlives pulses → lives 2,1,0, nolives=1 after the third; a fourth pulse keeps lives=0.
  - loadlives together with decrementlives → lives=3, nolives=0.
- Debounce:
  - pb2_raw toggling 1/0 every 2 cycles for 20 cycles → pb2 stays 0.
  - pb2_raw steady 1 → pb2=1 exactly 7 cycles after the last bounce; release gives a symmetric fall.
- Closed loop with the FSM logic:
  - Press pb2 → PS startgame→play and loadlives.
  - Three collision pulses, each followed by 40 counting cycles → PS ends ST_NOPADDLES with nolives=1.
  - Press pb1 → PS=ST_STARTGAME.
